// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings shared by the sequencer and the output decode stage
package ctrl_pkg;
  typedef enum logic [2:0] {
    S1 = 3'b000,
    S2 = 3'b001,
    S3 = 3'b010,
    S4 = 3'b011,
    S5 = 3'b100,
    S6 = 3'b101,
    S7 = 3'b110,
    S8 = 3'b111
  } state_t;
endpackage

// File: rtl/ctrl_tap_cnt.sv
// ctrl_tap_cnt: MAC tap counter with clear, enable and terminal flag
// Ports: clk, rst_n (async active-low), clr (priority over en), en, len (vector length),
//        cnt (current index), term (cnt == len-1)
module ctrl_tap_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             term
);
  assign term = cnt == len - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: sample-rate-converter sequencer walking the allocation list per input strobe
// Ports: clk, rst_n (async active-low), in_strobe (new sample pulse), vec_len/list_end
//        (entry at pc, sampled on S1->S2), fsm_state (3-bit code), tap_cnt (S3 index),
//        busy (pass in progress), overrun (dropped strobe pulse)
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_strobe,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             list_end,
  output logic [2:0]       fsm_state,
  output logic [LEN_W-1:0] tap_cnt,
  output logic             busy,
  output logic             overrun
);
  state_t state, state_d;
  logic run, run_d, pending, pending_d, end_q, end_d, ovr_d, term;
  logic [LEN_W-1:0] len_q, len_d;
  ctrl_tap_cnt #(.LEN_W(LEN_W)) u_tap (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != S3 || term),
    .en   (state == S3),
    .len  (len_q),
    .cnt  (tap_cnt),
    .term (term)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S1;
      run     <= 1'b0;
      pending <= 1'b0;
      end_q   <= 1'b0;
      len_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      run     <= run_d;
      pending <= pending_d;
      end_q   <= end_d;
      len_q   <= len_d;
      overrun <= ovr_d;
    end
  always_comb begin
    state_d   = state;
    run_d     = run;
    pending_d = pending;
    end_d     = end_q;
    len_d     = len_q;
    ovr_d     = 1'b0;
    case (state)
      S1: if (run) begin
        state_d = S2;
        len_d   = vec_len == '0 ? LEN_W'(1) : vec_len;
        end_d   = list_end;
      end else if (in_strobe || pending) begin
        // a strobe arriving while a buffered one is consumed stays buffered
        state_d   = S7;
        run_d     = 1'b1;
        pending_d = pending && in_strobe;
      end
      S7: state_d = S1;
      S2: state_d = S3;
      S3: state_d = term ? S4 : S3;
      S4: state_d = S5;
      S5: state_d = S8;
      S8: state_d = end_q ? S6 : S1;
      S6: begin
        state_d = S1;
        run_d   = 1'b0;
      end
      default: state_d = S1;
    endcase
    if (run && in_strobe) begin
      ovr_d     = pending;
      pending_d = 1'b1;
    end
  end
  assign fsm_state = state;
  assign busy      = run;
endmodule
